// File: rtl/spi_peripheral_if.sv
// Serial pins plus the parallel word side of the SPI mode-0 target.
// The slave modport is the peripheral's view; master is the initiator/host view.
interface spi_peripheral_if #(
    parameter int FRAME_WIDTH = 24
);
    logic                   sck;
    logic                   cs;
    logic                   sdi;
    logic                   sdo;
    logic                   sdo_en;
    logic [FRAME_WIDTH-1:0] tx_data;
    logic [FRAME_WIDTH-1:0] rx_data;
    logic                   rx_valid;
    logic                   frame_err;

    modport slave (
        input  sck, cs, sdi, tx_data,
        output sdo, sdo_en, rx_data, rx_valid, frame_err
    );

    modport master (
        output sck, cs, sdi, tx_data,
        input  sdo, sdo_en, rx_data, rx_valid, frame_err
    );
endinterface

// File: rtl/spi_peripheral.sv
// SPI mode-0 target: oversamples sck/cs/sdi in the clk domain, shifts a word in
// MSB-first on sck rising edges and a preloaded word out on sdo, flags short frames.
module spi_peripheral #(
    parameter int FRAME_WIDTH = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              nrst,
    spi_peripheral_if.slave   bus
);
    localparam int CW = $clog2(FRAME_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, sdi_sync;
    logic                   sck_q, cs_q;
    logic                   sck_s, cs_s, sdi_s;
    logic                   sck_rise, sck_fall, cs_fall, cs_rise;

    state_t                 state, next_state;
    logic [CW-1:0]          count;
    logic [FRAME_WIDTH-1:0] tx_shift, rx_shift, rx_word;
    logic                   rx_valid_q, frame_err_q;
    logic                   load, rx_step, tx_step, complete, abort;

    // The cs chain clears to 0 as well, so cs held low across reset release
    // never looks like a falling edge and a partial frame is never entered.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sck_sync <= '0;
            cs_sync  <= '0;
            sdi_sync <= '0;
            sck_q    <= 1'b0;
            cs_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge
            // value, which is what turns this chain into real synchronizer stages.
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], bus.sdi};
            sck_q    <= sck_s;
            cs_q     <= cs_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_q;
    assign sck_fall = ~sck_s & sck_q;
    assign cs_fall  = ~cs_s & cs_q;
    assign cs_rise  = cs_s & ~cs_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        next_state = state;
        load       = 1'b0;
        rx_step    = 1'b0;
        tx_step    = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    load       = 1'b1;
                    next_state = ACTIVE;
                end
            end
            ACTIVE: begin
                if (count == CW'(FRAME_WIDTH)) begin
                    complete   = 1'b1;
                    next_state = cs_rise ? IDLE : DONE;
                end else if (cs_rise) begin
                    // cs_rise wins over any sck edge seen in the same cycle
                    abort      = 1'b1;
                    next_state = IDLE;
                end else begin
                    rx_step = sck_rise;
                    tx_step = sck_fall && (count != '0);
                end
            end
            DONE: begin
                if (cs_rise) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // The count stops at FRAME_WIDTH because rx_step is never raised once full.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count       <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            rx_word     <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_valid_q  <= complete;
            frame_err_q <= abort;
            if (complete) rx_word <= rx_shift;
            if (load) begin
                tx_shift <= bus.tx_data;
                rx_shift <= '0;
                count    <= '0;
            end
            if (rx_step) begin
                rx_shift <= {rx_shift[FRAME_WIDTH-2:0], sdi_s};
                count    <= count + CW'(1);
            end
            if (tx_step) tx_shift <= {tx_shift[FRAME_WIDTH-2:0], 1'b0};
        end
    end

    assign bus.sdo       = (state == ACTIVE) & tx_shift[FRAME_WIDTH-1];
    assign bus.sdo_en    = (state != IDLE);
    assign bus.rx_data   = rx_word;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_peripheral.sv
// Directed plus randomized frames against a word-level model of the SPI target:
// expected sdo stream, received words and error pulses derived from the frame rules.
module tb_spi_peripheral;
    localparam int FW   = 24;
    localparam int SYNC = 2;

    logic clk  = 1'b0;
    logic nrst = 1'b0;

    spi_peripheral_if #(.FRAME_WIDTH(FW)) bus();

    spi_peripheral #(.FRAME_WIDTH(FW), .SYNC_STAGES(SYNC)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #10 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Monitor: every rx_valid pulse captures rx_data; error and pulse-shape counters.
    logic [FW-1:0] rv_q[$];
    int   fe_pulses  = 0;
    int   both_high  = 0;
    int   long_pulse = 0;
    logic rv_prev    = 1'b0;
    logic fe_prev    = 1'b0;

    always @(negedge clk) begin
        if (bus.rx_valid) rv_q.push_back(bus.rx_data);
        if (bus.frame_err) fe_pulses++;
        if (bus.rx_valid && bus.frame_err) both_high++;
        if ((bus.rx_valid && rv_prev) || (bus.frame_err && fe_prev)) long_pulse++;
        rv_prev = bus.rx_valid;
        fe_prev = bus.frame_err;
    end

    // Reference model state
    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] model_rx = '0;
    int            model_fe = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // sdo is sampled just before the rising edge, where a mode-0 initiator samples it
    task automatic sck_pulse(input logic d, input int half, output logic s);
        bus.sdi = d;
        wait_clk(half);
        s = bus.sdo;
        bus.sck = 1'b1;
        wait_clk(half);
        bus.sck = 1'b0;
    endtask

    function automatic logic [63:0] exp_sdo(input logic [FW-1:0] tx, input int n);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++) r = {r[62:0], (i < FW) ? tx[FW-1-i] : 1'b0};
        return r;
    endfunction

    task automatic do_frame(input string tag, input logic [FW-1:0] tx, input logic [63:0] din,
                            input int n, input int half, input int gap,
                            input int sw_bit, input logic [FW-1:0] tx_alt);
        logic [63:0]   dout = '0;
        logic          s;
        logic [FW-1:0] w = '0;
        bus.tx_data = tx;
        bus.cs = 1'b0;
        wait_clk(half);
        for (int i = 0; i < n; i++) begin
            if (i == sw_bit) bus.tx_data = tx_alt;
            sck_pulse(din[n-1-i], half, s);
            dout = {dout[62:0], s};
        end
        wait_clk(half);
        bus.cs = 1'b1;
        wait_clk(gap);
        check({tag, "/sdo_stream"}, dout, exp_sdo(tx, n));
        if (n >= FW) begin
            for (int i = 0; i < FW; i++) w = {w[FW-2:0], din[n-1-i]};
            exp_q.push_back(w);
            model_rx = w;
        end else begin
            model_fe++;
        end
    endtask

    task automatic results(input string tag);
        #1;
        check({tag, "/rx_valid_count"}, 64'(rv_q.size()), 64'(exp_q.size()));
        while (rv_q.size() > 0 && exp_q.size() > 0)
            check({tag, "/rx_data"}, 64'(rv_q.pop_front()), 64'(exp_q.pop_front()));
        rv_q.delete();
        exp_q.delete();
        check({tag, "/frame_err_count"}, 64'(fe_pulses), 64'(model_fe));
        check({tag, "/rx_data_held"}, 64'(bus.rx_data), 64'(model_rx));
        check({tag, "/sdo_en_idle"}, 64'(bus.sdo_en), 64'(0));
    endtask

    initial begin
        logic s;
        int   n;
        int   half;
        bus.sck = 1'b0;
        bus.cs = 1'b1;
        bus.sdi = 1'b0;
        bus.tx_data = '0;

        wait_clk(3);
        #1;
        check("reset/sdo", 64'(bus.sdo), 64'(0));
        check("reset/sdo_en", 64'(bus.sdo_en), 64'(0));
        check("reset/rx_data", 64'(bus.rx_data), 64'(0));
        check("reset/rx_valid", 64'(bus.rx_valid), 64'(0));
        check("reset/frame_err", 64'(bus.frame_err), 64'(0));
        nrst = 1'b1;
        wait_clk(5);

        // 1 MHz sck with 50 MHz clk: 25 clk per half period
        do_frame("nominal", 24'hA5C3F0, 64'h123456, 24, 25, 10, -1, '0);
        results("nominal");

        do_frame("overclock", 24'h5AC381, 64'hABCDEF << 16, 40, 25, 10, -1, '0);
        results("overclock");

        do_frame("short", 24'h0F1E2D, 64'h3FF, 10, 25, 10, -1, '0);
        results("short");

        do_frame("b2b_first", 24'h0F0F0F, 64'h000001, 24, 25, 4, -1, '0);
        do_frame("b2b_second", 24'h3C3C3C, 64'hFFFFFE, 24, 25, 10, -1, '0);
        results("b2b");

        // Reset while cs is low and sck keeps toggling
        bus.tx_data = 24'h5A5A5A;
        bus.cs = 1'b0;
        wait_clk(25);
        for (int i = 0; i < 12; i++) sck_pulse(i[0], 25, s);
        nrst = 1'b0;
        #1;
        model_rx = '0;
        check("midreset/sdo", 64'(bus.sdo), 64'(0));
        check("midreset/sdo_en", 64'(bus.sdo_en), 64'(0));
        check("midreset/rx_data", 64'(bus.rx_data), 64'(0));
        check("midreset/rx_valid", 64'(bus.rx_valid), 64'(0));
        check("midreset/frame_err", 64'(bus.frame_err), 64'(0));
        wait_clk(2);
        nrst = 1'b1;
        for (int i = 0; i < 16; i++) sck_pulse(i[1], 25, s);
        #1;
        check("midreset/sdo_en_after", 64'(bus.sdo_en), 64'(0));
        bus.cs = 1'b1;
        wait_clk(10);
        results("midreset");

        do_frame("after_reset", 24'hC0FFEE, 64'h7E1D5B, 24, 25, 10, -1, '0);
        results("after_reset");

        do_frame("tx_change", 24'h111111, 64'h9A8B7C, 24, 25, 10, 8, 24'h222222);
        results("tx_change");

        for (int k = 0; k < 8; k++) begin
            half = int'($urandom_range(12, 4));
            case ($urandom_range(2, 0))
                0:       n = FW;
                1:       n = FW + int'($urandom_range(8, 1));
                default: n = int'($urandom_range(FW - 1, 1));
            endcase
            do_frame("random", FW'($urandom), {$urandom, $urandom}, n, half, 8, -1, '0);
            results("random");
        end

        check("pulse/exclusive", 64'(both_high), 64'(0));
        check("pulse/one_cycle", 64'(long_pulse), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
- SPI mode-0 target: the responder end of the pedal's SPI link. Used where the FPGA is clocked by an external initiator (MCU or test host) for parameter writes and status reads.
- Samples external sck/cs/sdi in the clk domain, shifts a FRAME_WIDTH-bit word in MSB-first and shifts a preloaded word out on sdo.
- Flags a short frame as an error.

Parameters:
- FRAME_WIDTH, 24, bits per frame in each direction.
- SYNC_STAGES, 2, synchronizer flops on sck, cs and sdi (minimum 2).

Ports:
- clk  input  1  system clock; all state on posedge.
- nrst  input  1  asynchronous active-low reset.
- sck  input  1  external serial clock, idle low (mode 0).
- cs  input  1  external chip select, active low.
- sdi  input  1  serial data from the initiator.
- sdo  output  1  serial data to the initiator, MSB first.
- sdo_en  output  1  high while a frame is in progress (drives the pad OE).
- tx_data  input  FRAME_WIDTH  word to send; sampled at frame start.
- rx_data  output  FRAME_WIDTH  last complete received word.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- frame_err  output  1  one-cycle pulse when cs rises before FRAME_WIDTH bits are received.

Behaviour:
- Reset: async on nrst low.
  - sck and sdi sync chains clear to 0. The cs chain also clears to 0, so a cs held low through reset release never produces a falling edge and a partial frame is never entered.
  - Outputs: sdo=0, sdo_en=0, rx_data=0, rx_valid=0, frame_err=0, state=IDLE, bit count=0.
- Edge detect: a registered copy of each synced signal yields one-cycle sck_rise, sck_fall, cs_fall and cs_rise strobes.
- Input constraint: sck high and low times and cs setup/hold are each ≥ SYNC_STAGES+1 clk periods. Behaviour outside this constraint is undefined.
- States:
  - IDLE: sdo_en=0, sdo=0. On cs_fall: load tx_data into tx shift register, clear count and rx shift register, go to ACTIVE.
  - ACTIVE:
    - sdo_en=1; sdo = tx shift register MSB, so bit FRAME_WIDTH-1 of tx_data is on sdo the cycle after cs_fall.
    - On sck_rise: rx_shift <= {rx_shift, sdi_sync}; count++.
    - On sck_fall: tx shift left, zero fill. A falling edge with count==0 does not shift.
    - When count reaches FRAME_WIDTH: rx_data <= completed word and rx_valid pulses on the next cycle. Go to DONE.
    - On cs_rise with count < FRAME_WIDTH: frame_err pulses the next cycle, rx_data is unchanged, go to IDLE.
  - DONE:
    - sdo_en=1, sdo=0.
    - Extra sck edges are ignored. The count saturates at FRAME_WIDTH and never wraps, so an initiator clocking more than FRAME_WIDTH edges still yields exactly one rx_valid.
    - On cs_rise: go to IDLE with no error.
- Simultaneous events:
  - cs_rise and sck_rise in the same cycle: the sck edge is discarded and cs_rise wins.
  - cs_rise and the completing sck_rise cannot coincide under the input constraint.
- tx_data changes during a frame have no effect; it is only sampled at cs_fall.
- rx_valid and frame_err are never high together, and each lasts exactly one cycle.
- Latency: rx_valid is asserted SYNC_STAGES+2 clk cycles after the FRAME_WIDTH-th raw sck rising edge.

Test Plan:
- Nominal frame, FRAME_WIDTH=24: tx_data=0xA5C3F0; the bench drives sdi=0x123456 with sck=1 MHz, clk=50 MHz.
  - Required: sdo bit stream 0xA5C3F0, MSB first.
  - Required: rx_data=0x123456 with a single rx_valid pulse; frame_err stays 0.
- Over-clocked frame: 40 sck pulses, sdi=0xABCDEF then zeros.
  - Required: rx_data=0xABCDEF with one rx_valid.
  - Required: sdo=0 after bit 24; no frame_err.
- Short frame: cs rises after 10 sck pulses.
  - Required: one frame_err pulse, no rx_valid, rx_data keeps its previous value, sdo_en drops.
- Back-to-back frames: 0x000001 then 0xFFFFFE with a 4-clk cs-high gap.
  - Required: two rx_valid pulses with the matching rx_data values.
  - Required: the second frame transmits the tx_data value present at the second cs_fall.
- Reset mid-frame: nrst pulsed low after 12 bits while cs stays low and sck keeps toggling.
  - Required: outputs are 0 immediately; no rx_valid or frame_err until cs goes high then low.
  - Required: the next full frame is received correctly.
- tx_data change mid-frame: tx_data switched from 0x111111 to 0x222222 at bit 8.
  - Required: sdo carries 0x111111 for the whole frame.
